// File: rtl/scoreboard_unit_pkg.sv
// Shared pipeline constants and types for the load scoreboard.
// Holds the register-file geometry, the occupancy counter width and the bubble NOP.
package scoreboard_unit_pkg;
  localparam int REG_IDX_W = 5;
  localparam int REG_COUNT = 32;
  localparam int CNT_W = 3;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // E-stage record of the load that issued on the previous edge.
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
  } shadow_t;
endpackage

// File: rtl/scoreboard_unit_sb_counter.sv
// Saturating up/down occupancy counter for loads in flight.
// One increment and up to two decrements per edge; result clamped to [0, MAX].
module sb_counter
  import scoreboard_unit_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);
  localparam logic [CNT_W:0] MAX_V = (CNT_W+1)'(MAX);

  logic [CNT_W:0] sum;
  logic [CNT_W:0] dec_ext;
  logic [CNT_W:0] nxt;

  always_comb begin
    sum     = {1'b0, cnt} + {{CNT_W{1'b0}}, inc};
    dec_ext = {{(CNT_W-1){1'b0}}, dec};
    nxt     = sum;
    if (sum < dec_ext) nxt = '0;
    else               nxt = sum - dec_ext;
    if (nxt > MAX_V)   nxt = MAX_V;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= nxt[CNT_W-1:0];
  end

  assign full = (cnt == MAX_V[CNT_W-1:0]);
endmodule

// File: rtl/scoreboard_unit.sv
// Load scoreboard: tracks destination registers of in-flight loads and
// stalls decode on RAW/WAW hazards or when all load slots are occupied.
module scoreboard_unit
  import scoreboard_unit_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IssueValidD,
  input  logic        IsLoadD,
  input  logic [4:0]  RD_D,
  input  logic [4:0]  Rs1_D,
  input  logic [4:0]  Rs2_D,
  input  logic        FlushE,
  input  logic        LdDoneValid,
  input  logic [4:0]  LdDoneRd,
  output logic        StallF,
  output logic        StallD,
  output logic        BubbleE,
  output logic [31:0] Pending,
  output logic [2:0]  OutCnt
);
  logic [REG_COUNT-1:0] pend_q, pend_d;
  shadow_t              shadow_q, shadow_d;
  logic                 full;
  logic                 stall;
  logic                 set_fire, clear_fire, flush_fire;
  logic [1:0]           dec;

  // Bit 0 of pend_q is held at zero, so x0 operands never match.
  assign stall = pend_q[Rs1_D] | pend_q[Rs2_D] | pend_q[RD_D] | (IsLoadD & full);

  assign StallD  = stall;
  assign StallF  = stall;
  assign BubbleE = stall;

  // An instruction issues only when IssueValidD is high and decode is not stalled;
  // a taken branch in E squashes whatever tries to issue on the same edge.
  assign set_fire   = IssueValidD & IsLoadD & ~stall & ~FlushE;
  assign clear_fire = LdDoneValid & (OutCnt != '0);
  assign flush_fire = FlushE & shadow_q.valid;
  assign dec        = {1'b0, clear_fire} + {1'b0, flush_fire};

  always_comb begin
    pend_d = pend_q;
    if (clear_fire) pend_d[LdDoneRd]    = 1'b0;
    if (flush_fire) pend_d[shadow_q.rd] = 1'b0;
    if (set_fire)   pend_d[RD_D]        = 1'b1;
    pend_d[0] = 1'b0;
    shadow_d.valid = set_fire;
    shadow_d.rd    = set_fire ? RD_D : shadow_q.rd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= '0;
      shadow_q <= '0;
    end else begin
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
    end
  end

  sb_counter #(.MAX(MAX_OUTSTANDING)) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (set_fire),
    .dec   (dec),
    .cnt   (OutCnt),
    .full  (full)
  );

  assign Pending = pend_q;
endmodule

// File: tb/tb_scoreboard_unit.sv
// Self-checking bench for scoreboard_unit: directed scenarios plus a random
// phase, checked against a behavioural model through an expected-state queue.
module tb_scoreboard_unit;
  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        IssueValidD, IsLoadD, FlushE, LdDoneValid;
  logic [4:0]  RD_D, Rs1_D, Rs2_D, LdDoneRd;
  logic        StallF, StallD, BubbleE;
  logic [31:0] Pending;
  logic [2:0]  OutCnt;

  scoreboard_unit #(.MAX_OUTSTANDING(MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .IssueValidD (IssueValidD),
    .IsLoadD     (IsLoadD),
    .RD_D        (RD_D),
    .Rs1_D       (Rs1_D),
    .Rs2_D       (Rs2_D),
    .FlushE      (FlushE),
    .LdDoneValid (LdDoneValid),
    .LdDoneRd    (LdDoneRd),
    .StallF      (StallF),
    .StallD      (StallD),
    .BubbleE     (BubbleE),
    .Pending     (Pending),
    .OutCnt      (OutCnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [34:0] exp_q[$];

  // behavioural model state
  logic [31:0] m_pend;
  int          m_cnt;
  logic        m_sh_v;
  logic [4:0]  m_sh_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_cnt   = 0;
    m_sh_v  = 1'b0;
    m_sh_rd = '0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    IssueValidD = 1'b0; IsLoadD = 1'b0; RD_D = '0; Rs1_D = '0; Rs2_D = '0;
    FlushE = 1'b0; LdDoneValid = 1'b0; LdDoneRd = '0;
  endtask

  // Called at posedge+1; leaves at the next posedge+1 with inputs still applied.
  task automatic step(input int iv, input int ld, input int rd, input int rs1, input int rs2,
                      input int fl, input int dv, input int drd);
    logic        stall, set, clr, fls;
    logic [31:0] np;
    int          nc;
    logic [34:0] e;
    logic [4:0]  rd5, rs1_5, rs2_5, drd5;
    rd5 = 5'(rd); rs1_5 = 5'(rs1); rs2_5 = 5'(rs2); drd5 = 5'(drd);
    IssueValidD = 1'(iv); IsLoadD = 1'(ld); RD_D = rd5; Rs1_D = rs1_5; Rs2_D = rs2_5;
    FlushE = 1'(fl); LdDoneValid = 1'(dv); LdDoneRd = drd5;
    #3;
    stall = (rs1_5 != 0 && m_pend[rs1_5]) || (rs2_5 != 0 && m_pend[rs2_5]) ||
            (rd5 != 0 && m_pend[rd5]) || (ld != 0 && m_cnt == MAX);
    check("stall_d",  64'(StallD),  64'(stall));
    check("stall_f",  64'(StallF),  64'(stall));
    check("bubble_e", 64'(BubbleE), 64'(stall));
    set = (iv != 0) && (ld != 0) && !stall && (fl == 0);
    clr = (dv != 0) && (m_cnt > 0);
    fls = (fl != 0) && m_sh_v;
    np = m_pend;
    if (clr) np[drd5] = 1'b0;
    if (fls) np[m_sh_rd] = 1'b0;
    if (set && rd5 != 0) np[rd5] = 1'b1;
    nc = m_cnt + (set ? 1 : 0) - (clr ? 1 : 0) - (fls ? 1 : 0);
    if (nc < 0) nc = 0;
    if (nc > MAX) nc = MAX;
    m_sh_v = set;
    if (set) m_sh_rd = rd5;
    m_pend = np;
    m_cnt  = nc;
    exp_q.push_back({3'(nc), np});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check("pending", 64'(Pending), 64'(e[31:0]));
    check("out_cnt", 64'(OutCnt),  64'(e[34:32]));
  endtask

  // Reset is asserted with a load presented to show it is ignored.
  task automatic do_reset();
    rst = 1'b0;
    IssueValidD = 1'b1; IsLoadD = 1'b1; RD_D = 5'd5; Rs1_D = 5'd5; Rs2_D = '0;
    FlushE = 1'b0; LdDoneValid = 1'b0; LdDoneRd = '0;
    model_reset();
    @(posedge clk); #1;
    check("rst_pending", 64'(Pending), 64'd0);
    check("rst_out_cnt", 64'(OutCnt),  64'd0);
    check("rst_stall_d", 64'(StallD),  64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive_idle();
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    do_reset();

    // load-use on x5
    step(1, 1, 5, 0, 0, 0, 0, 0);
    check("lu_pend5", 64'(Pending[5]), 64'd1);
    step(1, 0, 10, 5, 0, 0, 0, 0);
    check("lu_stall_hold", 64'(StallD), 64'd1);
    step(1, 0, 10, 5, 0, 0, 1, 5);
    check("lu_release", 64'(StallD), 64'd0);
    step(1, 0, 10, 5, 0, 0, 0, 0);

    // load to x0
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 3, 0, 0, 0, 0, 0);
    check("x0_stall", 64'(StallD),  64'd0);
    check("x0_cnt",   64'(OutCnt),  64'd1);
    check("x0_pend",  64'(Pending), 64'd0);

    // occupancy full
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 1, i, 0, 0, 0, 0, 0);
    check("full_cnt", 64'(OutCnt), 64'd4);
    step(1, 1, 6, 0, 0, 0, 0, 0);
    check("full_stall", 64'(StallD), 64'd1);
    step(1, 1, 6, 0, 0, 0, 1, 1);
    check("full_release", 64'(StallD), 64'd0);
    step(1, 1, 6, 0, 0, 0, 0, 0);
    check("full_issue6", 64'(Pending), 64'h5c);
    check("full_cnt2",   64'(OutCnt),  64'd4);

    // coincident set and clear: same register, then different registers
    do_reset();
    step(1, 1, 3, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0, 1, 7);
    check("same_reg_pend", 64'(Pending), 64'h88);
    check("same_reg_cnt",  64'(OutCnt),  64'd1);
    step(1, 1, 8, 0, 0, 0, 1, 3);
    check("diff_reg_pend", 64'(Pending), 64'h180);
    check("diff_reg_cnt",  64'(OutCnt),  64'd1);

    // flush of the last issued load, with a coincident issue dropped
    do_reset();
    step(1, 1, 2, 0, 0, 0, 0, 0);
    step(1, 1, 9, 0, 0, 0, 0, 0);
    step(1, 1, 11, 0, 0, 1, 0, 0);
    check("flush_pend", 64'(Pending), 64'h4);
    check("flush_cnt",  64'(OutCnt),  64'd1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    check("flush_stale", 64'(OutCnt), 64'd1);

    // asynchronous reset mid-operation, then a stray completion
    do_reset();
    step(1, 1, 5, 0, 0, 0, 0, 0);
    drive_idle();
    #3;
    rst = 1'b0;
    #1;
    check("async_pend", 64'(Pending), 64'd0);
    check("async_cnt",  64'(OutCnt),  64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 1, 5);
    check("post_rst_cnt", 64'(OutCnt), 64'd0);

    // random traffic over a small register window to provoke hazards
    do_reset();
    repeat (300) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7),
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 7));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
